fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/fifo_wr_arbiter.sv | 74 +++++++
 tb/tb_fifo_wr_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared constants, tag width helper and FIFO word type for the write arbiter
package fifo_arb_pkg;

  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

  // Source tag width; never zero so a tag field always exists.
  function automatic int tag_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  localparam int DEFAULT_TAG_W = tag_w(DEFAULT_NUM_REQ);

  typedef struct packed {
    logic [DEFAULT_TAG_W-1:0]      tag;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter using a double-width mask-and-priority scan
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEFAULT_NUM_REQ,
  localparam int IDX_W   = tag_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [NUM_REQ-1:0]   mask;
  logic [NUM_REQ-1:0]   masked;
  logic [2*NUM_REQ-1:0] scan;
  int                   pos;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i > int'(last_grant));
    end
  end

  assign masked = req & mask;
  // Lower half holds requesters after the pointer, upper half the wrapped-around set.
  assign scan   = {req, masked};
  assign any    = |req;

  always_comb begin
    pos = 0;
    for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
      if (scan[j]) pos = j;
    end
  end

  assign grant_idx = IDX_W'((pos >= NUM_REQ) ? (pos - NUM_REQ) : pos);

  always_comb begin
    grant = '0;
    if (any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin credit-tracked write arbiter in front of a shared FIFO
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int DEPTH      = DEFAULT_DEPTH,
  localparam int TAG_W      = tag_w(NUM_REQ),
  localparam int CNT_W      = $clog2(DEPTH+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [TAG_W+DATA_WIDTH-1:0]   fifo_wr_data,
  input  logic                          fifo_rd_en,
  input  logic                          fifo_full,
  output logic [CNT_W-1:0]              credit_count,
  output logic                          err
);

  localparam logic [CNT_W-1:0] FULL_CREDIT = CNT_W'(DEPTH);

  logic [TAG_W-1:0]      last_grant;
  logic [TAG_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]    grant;
  logic                  any;
  logic                  can_accept;
  logic                  acc;
  logic                  pop;
  logic [DATA_WIDTH-1:0] payload;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any        (any)
  );

  assign can_accept = (credit_count != '0);
  assign req_ready  = (rst || !can_accept) ? '0 : grant;
  assign acc        = any && can_accept && !rst;
  assign pop        = fifo_rd_en;
  assign payload    = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= TAG_W'(NUM_REQ-1);
      credit_count <= FULL_CREDIT;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      err          <= 1'b0;
    end else begin
      fifo_wr_en <= acc;
      if (acc) begin
        last_grant   <= grant_idx;
        fifo_wr_data <= {grant_idx, payload};
      end
      // A pop with every slot already free is a consumer error; the count stays saturated.
      if (acc && !pop)
        credit_count <= credit_count - CNT_W'(1);
      else if (pop && !acc && credit_count != FULL_CREDIT)
        credit_count <= credit_count + CNT_W'(1);
      if ((pop && credit_count == FULL_CREDIT) || (fifo_wr_en && fifo_full))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized and directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int TW    = 2;
  localparam int CW    = 5;
  localparam logic [N-1:0] ALL = '1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_wr_en;
  logic [TW+DW-1:0] fifo_wr_data;
  logic            fifo_rd_en;
  logic            fifo_full;
  logic [CW-1:0]   credit_count;
  logic            err;

  fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_rd_en(fifo_rd_en), .fifo_full(fifo_full), .credit_count(credit_count),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: rotation pointer, free slots, FIFO fill level, expected outputs.
  int               m_lg;
  int               m_credit;
  int               m_occ;
  bit               m_err;
  bit               m_wr_en;
  logic [TW+DW-1:0] m_wr_data;
  bit               full_force;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(m_lg + k) % N]) return (m_lg + k) % N;
    end
    return -1;
  endfunction

  task automatic step(input bit r, input logic [N-1:0] v, input logic [N*DW-1:0] d, input bit rd);
    int         w;
    bit         hs;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    rst        = r;
    req_valid  = v;
    req_data   = d;
    fifo_rd_en = rd;
    fifo_full  = (m_occ >= DEPTH) || full_force;
    #1;
    w = model_winner(v);
    exp_ready = '0;
    if (!r && m_credit > 0 && w >= 0) exp_ready[w] = 1'b1;
    check_eq("req_ready", req_ready, exp_ready);
    @(posedge clk);
    if (r) begin
      m_lg = N-1; m_credit = DEPTH; m_occ = 0; m_err = 0; m_wr_en = 0; m_wr_data = '0;
    end else begin
      hs = (m_credit > 0) && (w >= 0);
      if ((rd && m_credit == DEPTH) || (m_wr_en && fifo_full)) m_err = 1;
      if (rd && m_occ > 0) m_occ--;
      if (m_wr_en && m_occ < DEPTH) m_occ++;
      if (hs && !rd) m_credit--;
      else if (rd && !hs && m_credit < DEPTH) m_credit++;
      m_wr_en = hs;
      if (hs) begin
        m_wr_data = {w[TW-1:0], d[w*DW +: DW]};
        m_lg = w;
      end
    end
    #1;
    check_eq("fifo_wr_en", fifo_wr_en, m_wr_en);
    if (m_wr_en) check_eq("fifo_wr_data", fifo_wr_data, m_wr_data);
    check_eq("credit_count", credit_count, m_credit);
    check_eq("err", err, m_err);
  endtask

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  initial begin
    logic [N*DW-1:0] d;
    fifo_word_t      wd;
    int              pushes;
    bit              rd;

    rst = 1'b1; req_valid = '0; req_data = '0; fifo_rd_en = 1'b0; fifo_full = 1'b0;
    full_force = 0;
    m_lg = N-1; m_credit = DEPTH; m_occ = 0; m_err = 0; m_wr_en = 0; m_wr_data = '0;

    // Reset held two cycles with every requester valid.
    step(1, ALL, rand_data(), 0);
    step(1, ALL, rand_data(), 0);
    check_eq("reset_credit", credit_count, 16);
    check_eq("reset_wr_en", fifo_wr_en, 0);
    check_eq("reset_err", err, 0);

    // Requester 2 streams five words.
    for (int k = 0; k < 5; k++) begin
      d = rand_data();
      d[2*DW +: DW] = 8'hA0 + 8'(k);
      step(0, 4'b0100, d, 0);
      wd.tag  = 2'd2;
      wd.data = 8'hA0 + 8'(k);
      check_eq("single_data", fifo_wr_data, wd);
      check_eq("single_push", fifo_wr_en, 1);
    end
    check_eq("single_credit", credit_count, 11);

    // Full contention rotates 0,1,2,3 from a fresh reset.
    step(1, '0, '0, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, ALL, rand_data(), 0);
      check_eq("rr_tag", fifo_wr_data[TW+DW-1:DW], k % N);
    end

    // Credit exhaustion, then a single pop admits exactly one more word.
    step(1, '0, '0, 0);
    for (int k = 0; k < DEPTH; k++) step(0, ALL, rand_data(), 0);
    check_eq("exhaust_credit", credit_count, 0);
    check_eq("exhaust_ready", req_ready, 0);
    step(0, ALL, rand_data(), 1);
    pushes = fifo_wr_en;
    for (int k = 0; k < 3; k++) begin
      step(0, ALL, rand_data(), 0);
      pushes += fifo_wr_en;
    end
    check_eq("one_more_push", pushes, 1);
    check_eq("exhaust_again", credit_count, 0);

    // Accept and pop together at one remaining credit.
    step(1, '0, '0, 0);
    for (int k = 0; k < DEPTH-1; k++) step(0, ALL, rand_data(), 0);
    check_eq("credit_one", credit_count, 1);
    step(0, ALL, rand_data(), 1);
    check_eq("acc_pop_credit", credit_count, 1);
    check_eq("acc_pop_push", fifo_wr_en, 1);
    check_eq("acc_pop_ready", |req_ready, 1);

    // Pop with every slot free sets a sticky error.
    step(1, '0, '0, 0);
    step(0, '0, '0, 1);
    check_eq("underflow_err", err, 1);
    check_eq("underflow_credit", credit_count, 16);
    for (int k = 0; k < 3; k++) step(0, '0, '0, 0);
    check_eq("err_sticky", err, 1);
    step(1, '0, '0, 0);
    check_eq("err_cleared", err, 0);

    // Push while the FIFO reports full.
    step(0, 4'b0001, rand_data(), 0);
    full_force = 1;
    step(0, '0, '0, 0);
    full_force = 0;
    check_eq("overflow_err", err, 1);

    // Reset in the cycle after a handshake drops the in-flight word.
    step(1, '0, '0, 0);
    step(0, 4'b0100, rand_data(), 0);
    check_eq("mid_push", fifo_wr_en, 1);
    step(1, ALL, rand_data(), 0);
    check_eq("mid_drop", fifo_wr_en, 0);
    check_eq("mid_credit", credit_count, 16);
    step(0, ALL, rand_data(), 0);
    check_eq("mid_first_tag", fifo_wr_data[TW+DW-1:DW], 0);

    // Random traffic with a well-behaved consumer and rare resets.
    step(1, '0, '0, 0);
    for (int k = 0; k < 400; k++) begin
      rd = (m_occ > 0) && ($urandom_range(0, 2) == 0);
      step($urandom_range(0, 99) == 0, N'($urandom), rand_data(), rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
